// File: rtl/cube_pkg.sv
// rtl/cube_pkg.sv - shared types, geometry defaults and edge table for the cube edge sequencer
package cube_pkg;

    localparam int XLENGTH_DEF = 120;
    localparam int XDIAG_DEF   = 50;
    localparam int YDIAG_DEF   = 90;
    localparam int TIMEOUT_DEF = 2048;

    localparam logic [3:0] LAST_EDGE = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT,
        NEXT,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } vertex_t;

    // Vertex indices per edge, edge 0 in the low 3 bits, edge 8 in the top 3 bits.
    localparam logic [26:0] EDGE_P0 = {3'd6, 3'd6, 3'd0, 3'd0, 3'd5, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [26:0] EDGE_P1 = {3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1};

    function automatic logic [2:0] edge_p0(input logic [3:0] idx);
        logic [2:0] v;
        v = 3'd0;
        if (idx <= LAST_EDGE) begin
            v = EDGE_P0[3*idx +: 3];
        end
        return v;
    endfunction

    function automatic logic [2:0] edge_p1(input logic [3:0] idx);
        logic [2:0] v;
        v = 3'd0;
        if (idx <= LAST_EDGE) begin
            v = EDGE_P1[3*idx +: 3];
        end
        return v;
    endfunction

endpackage

// File: rtl/cube_vertex_calc.sv
// rtl/cube_vertex_calc.sv - registered origin-to-seven-vertices arithmetic for the isometric cube
module cube_vertex_calc
    import cube_pkg::*;
#(
    parameter int XLENGTH = XLENGTH_DEF,
    parameter int XDIAG   = XDIAG_DEF,
    parameter int YDIAG   = YDIAG_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [10:0]   i_xo,
    input  logic [9:0]    i_yo,
    output vertex_t [6:0] o_vert
);

    // Offsets pre-truncated so every sum wraps naturally at the coordinate width.
    localparam logic [10:0] C_XL   = 11'(XLENGTH);
    localparam logic [10:0] C_XD   = 11'(XDIAG);
    localparam logic [10:0] C_XLD  = 11'(XLENGTH + XDIAG);
    localparam logic [9:0]  C_YD   = 10'(YDIAG);
    localparam logic [9:0]  C_Y2D  = 10'(2 * YDIAG);

    vertex_t [6:0] r_vert;

    // Capture all seven vertices in one cycle when a new origin is presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vert <= '0;
        end else if (i_load) begin
            r_vert[0].x <= i_xo;
            r_vert[0].y <= i_yo;
            r_vert[1].x <= i_xo + C_XL;
            r_vert[1].y <= i_yo;
            r_vert[2].x <= i_xo + C_XLD;
            r_vert[2].y <= i_yo + C_YD;
            r_vert[3].x <= i_xo + C_XL;
            r_vert[3].y <= i_yo + C_Y2D;
            r_vert[4].x <= i_xo;
            r_vert[4].y <= i_yo + C_Y2D;
            r_vert[5].x <= i_xo - C_XD;
            r_vert[5].y <= i_yo + C_YD;
            r_vert[6].x <= i_xo + C_XD;
            r_vert[6].y <= i_yo + C_YD;
        end
    end

    assign o_vert = r_vert;

endmodule

// File: rtl/cube_edge_sequencer.sv
// rtl/cube_edge_sequencer.sv - time-shares one line engine across the nine cube edges
module cube_edge_sequencer
    import cube_pkg::*;
#(
    parameter int XLENGTH = XLENGTH_DEF,
    parameter int XDIAG   = XDIAG_DEF,
    parameter int YDIAG   = YDIAG_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic [10:0] x_offset,
    input  logic [9:0]  y_offset,
    output logic        eng_start,
    output logic [10:0] eng_x0,
    output logic [9:0]  eng_y0,
    output logic [10:0] eng_x1,
    output logic [9:0]  eng_y1,
    input  logic        eng_done,
    output logic [3:0]  edge_idx,
    output logic        busy,
    output logic        seq_done,
    output logic        timeout_err,
    output logic        overrun
);

    // r_cnt counts cycles since the start pulse; an edge is abandoned on the
    // cycle the count would reach TIMEOUT-1, so the start-to-start spacing of a
    // skipped edge equals TIMEOUT.
    localparam int              CW         = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]   C_TO_LIMIT = CW'(TIMEOUT - 1);

    seq_state_t    r_state;
    logic [10:0]   r_xo;
    logic [9:0]    r_yo;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_edge_idx;
    logic          r_eng_start;
    logic          r_seq_done;
    logic          r_timeout_err;

    logic [CW-1:0] w_cnt_inc;
    logic          w_calc;
    vertex_t [6:0] w_vert;
    vertex_t       w_p0;
    vertex_t       w_p1;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_calc    = (r_state == CALC);

    cube_vertex_calc #(
        .XLENGTH (XLENGTH),
        .XDIAG   (XDIAG),
        .YDIAG   (YDIAG)
    ) u_vertex_calc (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_calc),
        .i_xo   (r_xo),
        .i_yo   (r_yo),
        .o_vert (w_vert)
    );

    // Sequencer: accept a pass, let vertices settle, then issue/await each edge in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_xo          <= '0;
            r_yo          <= '0;
            r_cnt         <= '0;
            r_edge_idx    <= '0;
            r_eng_start   <= 1'b0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_eng_start <= 1'b0;
            r_seq_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_start && enable) begin
                        r_xo          <= x_offset;
                        r_yo          <= y_offset;
                        r_timeout_err <= 1'b0;
                        r_edge_idx    <= '0;
                        r_state       <= CALC;
                    end
                end
                CALC: begin
                    r_eng_start <= 1'b1;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
                    r_cnt   <= w_cnt_inc;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (eng_done) begin
                        r_state <= NEXT;
                    end else if (w_cnt_inc >= C_TO_LIMIT) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= NEXT;
                    end
                end
                NEXT: begin
                    r_cnt <= '0;
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (r_edge_idx == LAST_EDGE) begin
                        r_state <= DONE;
                    end else begin
                        r_edge_idx  <= r_edge_idx + 4'd1;
                        r_eng_start <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                DONE: begin
                    r_seq_done <= 1'b1;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Endpoints follow the registered vertices and edge index, so they hold steady
    // from ISSUE until the edge index moves on.
    always_comb begin
        w_p0 = w_vert[edge_p0(r_edge_idx)];
        w_p1 = w_vert[edge_p1(r_edge_idx)];
    end

    assign eng_start   = r_eng_start;
    assign eng_x0      = w_p0.x;
    assign eng_y0      = w_p0.y;
    assign eng_x1      = w_p1.x;
    assign eng_y1      = w_p1.y;
    assign edge_idx    = r_edge_idx;
    assign busy        = (r_state != IDLE);
    assign seq_done    = r_seq_done;
    assign timeout_err = r_timeout_err;
    assign overrun     = frame_start && busy;

endmodule

// File: tb/tb_cube_edge_sequencer.sv
// tb/tb_cube_edge_sequencer.sv - self-checking bench for cube_edge_sequencer
module tb_cube_edge_sequencer;

    localparam int TB_TIMEOUT = 16;
    localparam int GX_LEN     = 120;
    localparam int GX_DIAG    = 50;
    localparam int GY_DIAG    = 90;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] x_offset = '0;
    logic [9:0]  y_offset = '0;
    logic        eng_done = 1'b0;
    logic        eng_start;
    logic [10:0] eng_x0, eng_x1;
    logic [9:0]  eng_y0, eng_y1;
    logic [3:0]  edge_idx;
    logic        busy, seq_done, timeout_err, overrun;

    cube_edge_sequencer #(
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .x_offset    (x_offset),
        .y_offset    (y_offset),
        .eng_start   (eng_start),
        .eng_x0      (eng_x0),
        .eng_y0      (eng_y0),
        .eng_x1      (eng_x1),
        .eng_y1      (eng_y1),
        .eng_done    (eng_done),
        .edge_idx    (edge_idx),
        .busy        (busy),
        .seq_done    (seq_done),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int idx;
        int x0;
        int y0;
        int x1;
        int y1;
    } start_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pass_t = 0;

    logic nx_fs = 1'b0;
    logic nx_en = 1'b1;
    logic nx_rst = 1'b1;
    int   nx_xo = 0;
    int   nx_yo = 0;

    int eng_k = 3;
    int mute_edge = -1;
    int done_cd = -1;

    start_t starts[$];
    int     sd_q[$];
    int     sd_te[$];
    int     ov_q[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs just after the edge, run the engine model, sample at the negedge.
    task automatic step();
        start_t s;
        @(posedge clk);
        cyc++;
        #1;
        reset       = nx_rst;
        enable      = nx_en;
        frame_start = nx_fs;
        nx_fs       = 1'b0;
        x_offset    = 11'(nx_xo);
        y_offset    = 10'(nx_yo);
        eng_done    = 1'b0;
        if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) begin
                eng_done = 1'b1;
                done_cd  = -1;
            end
        end
        @(negedge clk);
        if (eng_start) begin
            s.cyc = cyc;
            s.idx = int'(edge_idx);
            s.x0  = int'(eng_x0);
            s.y0  = int'(eng_y0);
            s.x1  = int'(eng_x1);
            s.y1  = int'(eng_y1);
            starts.push_back(s);
            if (starts.size() - 1 != mute_edge) done_cd = eng_k;
        end
        if (seq_done) begin
            sd_q.push_back(cyc);
            sd_te.push_back(int'(timeout_err));
        end
        if (overrun) ov_q.push_back(cyc);
    endtask

    // Geometric reference: vertices from the origin, then the edge table.
    function automatic void ref_edge(input int xo, input int yo, input int e,
                                     output int x0, output int y0, output int x1, output int y1);
        int vx[7];
        int vy[7];
        int p0[9] = '{0, 1, 2, 3, 5, 0, 0, 6, 6};
        int p1[9] = '{1, 2, 3, 4, 4, 5, 6, 4, 2};
        vx = '{xo, xo + GX_LEN, xo + GX_LEN + GX_DIAG, xo + GX_LEN, xo, xo - GX_DIAG, xo + GX_DIAG};
        vy = '{yo, yo, yo + GY_DIAG, yo + 2 * GY_DIAG, yo + 2 * GY_DIAG, yo + GY_DIAG, yo + GY_DIAG};
        x0 = (vx[p0[e]] + 2048) % 2048;
        y0 = vy[p0[e]] % 1024;
        x1 = (vx[p1[e]] + 2048) % 2048;
        y1 = vy[p1[e]] % 1024;
    endfunction

    task automatic check_pass(input int xo, input int yo, input int k, input int mute);
        int x0, y0, x1, y1;
        int exp_c;
        int exp_seq;
        exp_seq = pass_t + 2;
        for (int e = 0; e < 9; e++) exp_seq += (e == mute) ? TB_TIMEOUT : k + 2;
        exp_seq += 1;
        chk("n_starts", starts.size(), 9);
        exp_c = pass_t + 2;
        for (int e = 0; e < 9 && e < starts.size(); e++) begin
            ref_edge(xo, yo, e, x0, y0, x1, y1);
            chk($sformatf("e%0d_idx", e), starts[e].idx, e);
            chk($sformatf("e%0d_cyc", e), starts[e].cyc - pass_t, exp_c - pass_t);
            chk($sformatf("e%0d_x0", e), starts[e].x0, x0);
            chk($sformatf("e%0d_y0", e), starts[e].y0, y0);
            chk($sformatf("e%0d_x1", e), starts[e].x1, x1);
            chk($sformatf("e%0d_y1", e), starts[e].y1, y1);
            exp_c += (e == mute) ? TB_TIMEOUT : k + 2;
        end
        chk("n_seq_done", sd_q.size(), 1);
        if (sd_q.size() > 0) begin
            chk("seq_done_cyc", sd_q[0] - pass_t, exp_seq - pass_t);
            chk("seq_timeout_err", sd_te[0], (mute >= 0) ? 1 : 0);
        end
    endtask

    task automatic do_pass(input int xo, input int yo, input int k, input int mute, input int refire);
        starts.delete();
        sd_q.delete();
        sd_te.delete();
        ov_q.delete();
        eng_k     = k;
        mute_edge = mute;
        done_cd   = -1;
        nx_xo     = xo;
        nx_yo     = yo;
        nx_fs     = 1'b1;
        step();
        pass_t = cyc;
        step();
        chk("te_cleared", int'(timeout_err), 0);
        chk("busy_calc", int'(busy), 1);
        for (int n = 0; n < 400 && sd_q.size() == 0; n++) begin
            if (refire > 0 && cyc == pass_t + refire - 1) begin
                nx_fs = 1'b1;
                nx_xo = 100;
            end
            step();
        end
        repeat (3) step();
        check_pass(xo, yo, k, mute);
        chk("n_overrun", ov_q.size(), (refire > 0) ? 1 : 0);
        if (refire > 0 && ov_q.size() > 0) chk("overrun_cyc", ov_q[0] - pass_t, refire);
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_eng_start"}, int'(eng_start), 0);
        chk({pfx, "_x0"}, int'(eng_x0), 0);
        chk({pfx, "_y0"}, int'(eng_y0), 0);
        chk({pfx, "_x1"}, int'(eng_x1), 0);
        chk({pfx, "_y1"}, int'(eng_y1), 0);
        chk({pfx, "_edge_idx"}, int'(edge_idx), 0);
        chk({pfx, "_busy"}, int'(busy), 0);
        chk({pfx, "_seq_done"}, int'(seq_done), 0);
        chk({pfx, "_timeout_err"}, int'(timeout_err), 0);
        chk({pfx, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        int xo_r, yo_r, k_r, m_r;

        // Reset state
        nx_rst = 1'b1;
        nx_en  = 1'b1;
        repeat (2) step();
        check_all_zero("reset");
        nx_rst = 1'b0;
        step();

        // Nominal pass at (400,300), engine answers 3 cycles after each start
        do_pass(400, 300, 3, -1, 0);
        if (starts.size() == 9) begin
            chk("e0_x0_abs", starts[0].x0, 400);
            chk("e0_y0_abs", starts[0].y0, 300);
            chk("e0_x1_abs", starts[0].x1, 520);
            chk("e0_y1_abs", starts[0].y1, 300);
            chk("e4_x0_abs", starts[4].x0, 350);
            chk("e4_y0_abs", starts[4].y0, 390);
            chk("e4_x1_abs", starts[4].x1, 400);
            chk("e4_y1_abs", starts[4].y1, 480);
            chk("e8_x0_abs", starts[8].x0, 450);
            chk("e8_y0_abs", starts[8].y0, 390);
            chk("e8_x1_abs", starts[8].x1, 570);
            chk("e8_y1_abs", starts[8].y1, 390);
        end
        if (sd_q.size() > 0) chk("latency_48", sd_q[0] - pass_t, 48);

        // Engine silent on edge 2: skipped after the timeout, error sticks until next pass
        do_pass(400, 300, 3, 2, 0);
        if (starts.size() > 3) chk("timeout_gap", starts[3].cyc - starts[2].cyc, 16);
        chk("te_sticky", int'(timeout_err), 1);
        do_pass(123, 45, 2, -1, 0);

        // Second frame_start mid-pass with a new origin: overrun, origin unchanged
        do_pass(400, 300, 3, -1, 5);

        // X wrap at the left edge
        do_pass(20, 300, 3, -1, 0);
        if (starts.size() > 5) begin
            chk("wrap_e5_x0", starts[5].x0, 20);
            chk("wrap_e5_y0", starts[5].y0, 300);
            chk("wrap_e5_x1", starts[5].x1, 2018);
            chk("wrap_e5_y1", starts[5].y1, 390);
        end

        // Enable dropped while waiting on edge 3
        starts.delete();
        sd_q.delete();
        sd_te.delete();
        eng_k     = 3;
        mute_edge = -1;
        done_cd   = -1;
        nx_xo     = 400;
        nx_yo     = 300;
        nx_fs     = 1'b1;
        step();
        for (int n = 0; n < 100 && starts.size() < 4; n++) step();
        nx_en = 1'b0;
        repeat (30) step();
        chk("en_n_starts", starts.size(), 4);
        chk("en_n_seq_done", sd_q.size(), 0);
        chk("en_busy", int'(busy), 0);
        chk("en_edge_idx", int'(edge_idx), 3);
        nx_fs = 1'b1;
        step();
        step();
        chk("en_fs_ignored_busy", int'(busy), 0);
        repeat (10) step();
        chk("en_fs_ignored_starts", starts.size(), 4);
        nx_en = 1'b1;
        step();

        // Asynchronous reset in the middle of edge 6 WAIT
        starts.delete();
        sd_q.delete();
        eng_k     = 3;
        mute_edge = -1;
        done_cd   = -1;
        nx_xo     = 400;
        nx_yo     = 300;
        nx_fs     = 1'b1;
        step();
        for (int n = 0; n < 200 && starts.size() < 7; n++) step();
        step();
        chk("pre_rst_busy", int'(busy), 1);
        #2;
        reset  = 1'b1;
        nx_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        nx_rst = 1'b0;
        starts.delete();
        sd_q.delete();
        repeat (10) step();
        chk("rst_stray_starts", starts.size(), 0);
        chk("rst_stray_seq", sd_q.size(), 0);
        chk("rst_stray_busy", int'(busy), 0);
        do_pass(400, 300, 3, -1, 0);

        // Randomised passes against the geometric reference
        for (int p = 0; p < 4; p++) begin
            xo_r = int'($urandom_range(0, 2047));
            yo_r = int'($urandom_range(0, 1023));
            k_r  = int'($urandom_range(1, 6));
            m_r  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
            do_pass(xo_r, yo_r, k_r, m_r, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
